// File: rtl/bitboard_move_enumerator.sv
// Expands a 64-square bitboard into one beat per set square, lowest index first,
// tagging each beat with its ordinal and the frame's popcount.
module bitboard_move_enumerator (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_bits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_index,
  output logic [5:0]  out_seq,
  output logic [6:0]  out_count,
  output logic        out_last,
  output logic        out_empty
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [63:0] r_mask;
  logic [5:0]  r_seq;
  logic [6:0]  r_count;
  logic        r_empty;

  logic [63:0] w_maskLess1;
  logic [63:0] w_maskNext;
  logic [63:0] w_lowBit;
  logic [5:0]  w_lowIndex;
  logic [3:0]  w_groupCount [8];
  logic [4:0]  w_pairCount [4];
  logic [5:0]  w_quadCount [2];
  logic [6:0]  w_popcount;
  logic        w_isLast;
  logic        w_fire;
  logic        w_load;

  // Clearing the lowest set bit and isolating it share the same mask-1 term.
  assign w_maskLess1 = r_mask - 64'd1;
  assign w_maskNext  = r_mask & w_maskLess1;
  assign w_lowBit    = r_mask & ~w_maskLess1;

  always_comb begin
    w_lowIndex = '0;
    for (int i = 0; i < 64; i++) begin
      if (w_lowBit[i]) w_lowIndex = w_lowIndex | 6'(i);
    end
  end

  // Balanced adder tree: 8-bit groups, then pairs, quads and the final sum.
  always_comb begin
    for (int g = 0; g < 8; g++) begin
      w_groupCount[g] = '0;
      for (int b = 0; b < 8; b++) begin
        w_groupCount[g] = w_groupCount[g] + {3'b000, in_bits[8*g+b]};
      end
    end
    for (int p = 0; p < 4; p++) begin
      w_pairCount[p] = {1'b0, w_groupCount[2*p]} + {1'b0, w_groupCount[2*p+1]};
    end
    for (int q = 0; q < 2; q++) begin
      w_quadCount[q] = {1'b0, w_pairCount[2*q]} + {1'b0, w_pairCount[2*q+1]};
    end
    w_popcount = {1'b0, w_quadCount[0]} + {1'b0, w_quadCount[1]};
  end

  assign w_isLast = r_empty || (w_maskNext == 64'd0);
  assign w_fire   = (r_state == EMIT) && out_ready;
  assign w_load   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_seq   <= '0;
      r_count <= '0;
      r_empty <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_mask  <= in_bits;
        r_seq   <= '0;
        r_count <= w_popcount;
        r_empty <= (in_bits == 64'd0);
      end else if (w_fire) begin
        r_mask <= w_maskNext;
        r_seq  <= r_seq + 6'd1;
      end
    end
  end

  // Outputs are forced to zero outside EMIT so an idle block presents a clean stream.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_index   = '0;
    out_seq     = '0;
    out_count   = '0;
    out_last    = 1'b0;
    out_empty   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_index = r_empty ? 6'd0 : w_lowIndex;
        out_seq   = r_seq;
        out_count = r_count;
        out_last  = w_isLast;
        out_empty = r_empty;
        in_ready  = w_fire && w_isLast;
        if (w_fire && w_isLast) w_nextState = in_valid ? EMIT : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitboard_move_enumerator.sv
// Self-checking bench: expected beats are queued from a scan model at load time
// and popped on every output handshake.
module tb_bitboard_move_enumerator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic [5:0]  out_seq;
  logic [6:0]  out_count;
  logic        out_last;
  logic        out_empty;

  typedef struct packed {
    logic [5:0] idx;
    logic [5:0] seq;
    logic [6:0] cnt;
    logic       last;
    logic       empty;
  } beat_t;

  beat_t sbq[$];
  beat_t e;
  int    errors = 0;
  int    checks = 0;

  bitboard_move_enumerator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_seq   (out_seq),
    .out_count (out_count),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  always #5 clk = ~clk;

  // Scan model: walk squares upward, numbering set bits and flagging the final one.
  function automatic void push_frame(input logic [63:0] b);
    beat_t x;
    int    c;
    int    s;
    c = 0;
    for (int i = 0; i < 64; i++) if (b[i]) c++;
    if (b == 64'd0) begin
      x.idx = 6'd0; x.seq = 6'd0; x.cnt = 7'd0; x.last = 1'b1; x.empty = 1'b1;
      sbq.push_back(x);
    end else begin
      s = 0;
      for (int i = 0; i < 64; i++) begin
        if (b[i]) begin
          x.idx = 6'(i); x.seq = 6'(s); x.cnt = 7'(c);
          x.last = (s == c - 1); x.empty = 1'b0;
          sbq.push_back(x);
          s++;
        end
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_index, out_seq, out_count, out_last, out_empty} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got valid=%0b idx=%0d seq=%0d cnt=%0d last=%0b empty=%0b want all 0",
               out_valid, out_index, out_seq, out_count, out_last, out_empty);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready);
    end
  endtask

  // One frame with out_ready held high; expCycles covers the load cycle plus every beat.
  task automatic test_frames(input logic [63:0] bits, input int expCycles, input string name);
    bit loaded;
    int n;
    loaded = 1'b0;
    n = 0;
    while (n < 200 && !(loaded && sbq.size() == 0)) begin
      @(negedge clk);
      in_valid = !loaded; in_bits = bits; out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) begin
        push_frame(in_bits);
        loaded = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s extra_beat got idx=%0d want no beat", name, out_index);
        end else begin
          e = sbq.pop_front();
          if ({out_index, out_seq, out_count, out_last, out_empty} !== e) begin
            errors++;
            $display("[TB] FAIL %s beat got idx=%0d seq=%0d cnt=%0d last=%0b empty=%0b want idx=%0d seq=%0d cnt=%0d last=%0b empty=%0b",
                     name, out_index, out_seq, out_count, out_last, out_empty,
                     e.idx, e.seq, e.cnt, e.last, e.empty);
          end
        end
      end
      n++;
    end
    checks++;
    if (n !== expCycles || !loaded || sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s cycles got %0d (pending %0d) want %0d", name, n, sbq.size(), expCycles);
      sbq.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s idle_after got in_ready=%0b out_valid=%0b want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int    frame;
    int    n;
    bit    stalled;
    bit    expectNext;
    logic [20:0] held;
    frame = 0; n = 0; stalled = 1'b0; expectNext = 1'b0; held = '0;
    while (n < 400 && !(frame == 2 && sbq.size() == 0)) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (frame < 2);
      in_bits   = (frame == 0) ? 64'h0000_0000_00F0_0000 : 64'h2;
      #1;
      if (stalled) begin
        checks++;
        if ({out_index, out_seq, out_count, out_last, out_empty} !== held || out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall_stable got valid=%0b outs=%h want valid=1 outs=%h",
                   out_valid, {out_index, out_seq, out_count, out_last, out_empty}, held);
        end
      end
      if (expectNext) begin
        checks++;
        if (out_valid !== 1'b1 || out_index !== 6'd1) begin
          errors++;
          $display("[TB] FAIL no_bubble got valid=%0b idx=%0d want valid=1 idx=1", out_valid, out_index);
        end
        expectNext = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b extra_beat got idx=%0d want no beat", out_index);
        end else begin
          e = sbq.pop_front();
          if ({out_index, out_seq, out_count, out_last, out_empty} !== e) begin
            errors++;
            $display("[TB] FAIL b2b beat got idx=%0d seq=%0d cnt=%0d last=%0b empty=%0b want idx=%0d seq=%0d cnt=%0d last=%0b empty=%0b",
                     out_index, out_seq, out_count, out_last, out_empty,
                     e.idx, e.seq, e.cnt, e.last, e.empty);
          end
          if (e.last && e.idx == 6'd23) expectNext = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        push_frame(in_bits);
        frame++;
      end
      stalled = out_valid && !out_ready;
      held    = {out_index, out_seq, out_count, out_last, out_empty};
      n++;
    end
    checks++;
    if (frame != 2 || sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_timeout got frames=%0d pending=%0d want 2 0", frame, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bit loaded;
    int pops;
    int n;
    loaded = 1'b0; pops = 0; n = 0;
    while (n < 50 && pops < 3) begin
      @(negedge clk);
      in_valid = !loaded; in_bits = 64'hFF; out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) begin
        push_frame(in_bits);
        loaded = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        e = sbq.pop_front();
        if ({out_index, out_seq, out_count, out_last, out_empty} !== e) begin
          errors++;
          $display("[TB] FAIL midframe beat got idx=%0d seq=%0d cnt=%0d want idx=%0d seq=%0d cnt=%0d",
                   out_index, out_seq, out_count, e.idx, e.seq, e.cnt);
        end
        pops++;
      end
      n++;
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 7'd0) begin
      errors++;
      $display("[TB] FAIL midframe_reset got valid=%0b in_ready=%0b cnt=%0d want 0 1 0",
               out_valid, in_ready, out_count);
    end
    test_frames(64'h10, 2, "post_reset");
  endtask

  initial begin
    test_reset();
    test_frames(64'h0000_0000_0000_0001, 2, "single_bit");
    test_frames(64'h8000_0000_0000_0001, 3, "edge_squares");
    test_frames(64'h0, 2, "empty_board");
    test_frames({64{1'b1}}, 65, "full_board");
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
